// File: rtl/pwm4sdr_pkg.sv
// pwm4sdr_pkg: sample-link constants and types shared by the PWM encoder and the decoder/latch side
package pwm4sdr_pkg;
  localparam int SAMPLE_W_DEF = 8;
  localparam int MIDSCALE = 2 ** (SAMPLE_W_DEF - 1);
  typedef logic signed [SAMPLE_W_DEF-1:0] sample_t;
endpackage

// File: rtl/pwm_frame_counter.sv
// pwm_frame_counter: tick prescaler plus frame phase counter, flags the first tick of each frame
module pwm_frame_counter import pwm4sdr_pkg::*; #(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int PRESCALE = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  output logic [SAMPLE_W-1:0] phase_o,
  output logic                boundary_o
);
  localparam int TW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [TW-1:0] tick_q, tick_d;
  logic [SAMPLE_W-1:0] phase_q, phase_d;
  logic tick_wrap;
  always_comb begin
    tick_wrap = tick_q == TW'(PRESCALE - 1);
    tick_d = !enable || tick_wrap ? '0 : tick_q + 1'b1;
    phase_d = !enable ? '0 : tick_wrap ? phase_q + 1'b1 : phase_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_q <= '0;
      phase_q <= '0;
    end else begin
      tick_q <= tick_d;
      phase_q <= phase_d;
    end
  end
  assign phase_o = phase_q;
  assign boundary_o = enable && phase_q == '0 && tick_q == '0;
endmodule

// File: rtl/pwm_encoder.sv
// pwm_encoder: turns a valid/ready stream of signed samples into one PWM frame per sample
module pwm_encoder import pwm4sdr_pkg::*; #(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int PRESCALE = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic signed [SAMPLE_W-1:0] data_in,
  input  logic                       data_valid,
  output logic                       data_ready,
  output logic                       pwm_out,
  output logic                       frame_start,
  output logic                       underrun,
  input  logic                       underrun_clr
);
  logic [SAMPLE_W-1:0] phase, duty;
  logic boundary, take;
  logic signed [SAMPLE_W-1:0] hold_q, hold_d, active_q, active_d;
  logic hold_full_q, hold_full_d, pwm_q, pwm_d, fs_q, underrun_q, underrun_d;
  pwm_frame_counter #(.SAMPLE_W(SAMPLE_W), .PRESCALE(PRESCALE)) u_cnt (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .phase_o(phase),
    .boundary_o(boundary)
  );
  // duty is taken from the next active sample so the first cycle of a frame already uses it
  always_comb begin
    take = data_valid & ~hold_full_q;
    active_d = boundary & hold_full_q ? hold_q : active_q;
    hold_d = take ? data_in : hold_q;
    hold_full_d = take | (hold_full_q & ~boundary);
    underrun_d = (boundary & ~hold_full_q) | (underrun_q & ~underrun_clr);
    duty = {~active_d[SAMPLE_W-1], active_d[SAMPLE_W-2:0]};
    pwm_d = enable & (phase < duty);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_q <= '0;
      active_q <= '0;
      hold_full_q <= 1'b0;
      pwm_q <= 1'b0;
      fs_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      active_q <= active_d;
      hold_full_q <= hold_full_d;
      pwm_q <= pwm_d;
      fs_q <= boundary;
      underrun_q <= underrun_d;
    end
  end
  assign data_ready = ~hold_full_q;
  assign pwm_out = pwm_q;
  assign frame_start = fs_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_pwm_encoder.sv
// tb_pwm_encoder: directed stimulus with a frame-level scoreboard of high-time per PWM frame
module tb_pwm_encoder;
  import pwm4sdr_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n, enable, data_valid, data_ready, pwm_out, frame_start, underrun, underrun_clr;
  sample_t data_in;
  logic rst2, en2, dv2, dr2, pwm2, fs2, ur2;
  sample_t d2;
  int checks = 0, passed = 0;
  int exp_q[$];
  bit done2 = 1'b0;
  pwm_encoder #(.PRESCALE(1)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .pwm_out(pwm_out), .frame_start(frame_start), .underrun(underrun),
    .underrun_clr(underrun_clr)
  );
  pwm_encoder #(.PRESCALE(3)) dut3 (
    .clk(clk), .reset_n(rst2), .enable(en2), .data_in(d2), .data_valid(dv2),
    .data_ready(dr2), .pwm_out(pwm2), .frame_start(fs2), .underrun(ur2),
    .underrun_clr(1'b0)
  );
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", n, act, exp);
  endtask
  task automatic wait_fs(input string n);
    int c = 0;
    do begin @(negedge clk); c++; end while (!frame_start && c < 1000);
    chk({"frame_start_", n}, int'(frame_start), 1);
  endtask
  task automatic send(input sample_t s, input string n);
    int c = 0;
    data_in = s;
    data_valid = 1'b1;
    while (!data_ready && c < 1000) begin @(negedge clk); c++; end
    @(negedge clk);
    data_valid = 1'b0;
    chk({n, "_ready_low"}, int'(data_ready), 0);
  endtask
  task automatic clr_ur(input string n);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk(n, int'(underrun), 0);
  endtask
  // scoreboard monitor: measures each complete frame, aborting frames cut by disable or reset
  initial begin : monitor
    bit in_frame;
    int hi, len, e;
    in_frame = 1'b0;
    hi = 0;
    len = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n || !enable) in_frame = 1'b0;
      else if (frame_start) begin
        if (in_frame) begin
          if (exp_q.size() == 0) chk("sb_extra_frame", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            chk("sb_high_count", hi, e);
            chk("sb_frame_period", len, 256);
          end
        end
        in_frame = 1'b1;
        hi = int'(pwm_out);
        len = 1;
      end else if (in_frame) begin
        hi += int'(pwm_out);
        len++;
      end
    end
  end
  initial begin : prescale3
    int c, hi;
    rst2 = 1'b0; en2 = 1'b0; dv2 = 1'b0; d2 = sample_t'(0);
    repeat (3) @(negedge clk);
    rst2 = 1'b1;
    d2 = sample_t'(64);
    dv2 = 1'b1;
    @(negedge clk);
    dv2 = 1'b0;
    chk("p3_ready_low", int'(dr2), 0);
    en2 = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!fs2 && c < 2000);
    chk("p3_first_frame_start", int'(fs2), 1);
    chk("p3_no_underrun", int'(ur2), 0);
    hi = 0;
    c = 0;
    do begin hi += int'(pwm2); @(negedge clk); c++; end while (!fs2 && c < 2000);
    chk("p3_high_clk", hi, 576);
    chk("p3_frame_period", c, 768);
    done2 = 1'b1;
  end
  initial begin : stim
    sample_t v2[3], v3[3];
    int e2[3], e3[3];
    int c;
    v2 = '{sample_t'(-128), sample_t'(0), sample_t'(127)};
    e2 = '{0, 128, 255};
    v3 = '{sample_t'(10), sample_t'(-50), sample_t'(100)};
    e3 = '{138, 78, 228};
    reset_n = 1'b0; enable = 1'b0; data_valid = 1'b0; data_in = sample_t'(0); underrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_ready", int'(data_ready), 1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_pwm", int'(pwm_out), 0);
    exp_q.push_back(MIDSCALE);
    enable = 1'b1;
    wait_fs("t1a");
    chk("t1_underrun_set", int'(underrun), 1);
    exp_q.push_back(MIDSCALE);
    repeat (10) @(negedge clk);
    clr_ur("t1_underrun_clr");
    wait_fs("t1b");
    chk("t1_underrun_reset", int'(underrun), 1);
    clr_ur("t2_underrun_clr");
    for (int i = 0; i < 3; i++) begin
      send(v2[i], "t2");
      exp_q.push_back(e2[i]);
      wait_fs("t2");
      chk("t2_no_underrun", int'(underrun), 0);
    end
    data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = v3[i];
      c = 0;
      while (!data_ready && c < 1000) begin @(negedge clk); c++; end
      chk("t3_ready_high", int'(data_ready), 1);
      exp_q.push_back(e3[i]);
      @(negedge clk);
      chk("t3_ready_drop", int'(data_ready), 0);
    end
    data_valid = 1'b0;
    exp_q.push_back(228);
    wait_fs("t3a");
    chk("t3_no_underrun", int'(underrun), 0);
    wait_fs("t3b");
    chk("t3_underrun_starved", int'(underrun), 1);
    exp_q.push_back(228);
    clr_ur("t4_underrun_clr");
    repeat (254) @(negedge clk);
    data_in = sample_t'(-64);
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    chk("t4_boundary_frame_start", int'(frame_start), 1);
    chk("t4_underrun", int'(underrun), 1);
    chk("t4_held_ready_low", int'(data_ready), 0);
    exp_q.push_back(64);
    wait_fs("t4b");
    chk("t4_hold_moved_ready", int'(data_ready), 1);
    wait_fs("t4c");
    repeat (50) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("t6_disable_pwm_low", int'(pwm_out), 0);
    chk("t6_disable_fs_low", int'(frame_start), 0);
    send(sample_t'(20), "t6_idle");
    repeat (5) @(negedge clk);
    chk("t6_disable_pwm_still_low", int'(pwm_out), 0);
    exp_q.push_back(148);
    enable = 1'b1;
    wait_fs("t6a");
    chk("t6_reenable_ready", int'(data_ready), 1);
    wait_fs("t6b");
    repeat (30) @(negedge clk);
    send(sample_t'(90), "t6_pre_reset");
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t6_reset_pwm", int'(pwm_out), 0);
    chk("t6_reset_fs", int'(frame_start), 0);
    chk("t6_reset_underrun", int'(underrun), 0);
    chk("t6_reset_ready", int'(data_ready), 1);
    exp_q.push_back(MIDSCALE);
    @(negedge clk);
    reset_n = 1'b1;
    wait_fs("t6c");
    chk("t6_hold_discarded_underrun", int'(underrun), 1);
    wait_fs("t6d");
    chk("sb_queue_drained", exp_q.size(), 0);
    c = 0;
    while (!done2 && c < 5000) begin @(negedge clk); c++; end
    chk("p3_done", int'(done2), 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
